// File: rtl/mm_seq.sv
// mm_seq: drives matrix_ops through an 8x8 32-bit matrix product.
// Fetches A/B rows, issues one MAC step per A element, writes C rows.
module mm_seq (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  output logic         busy,
  output logic         done,
  output logic [2:0]   a_raddr,
  input  logic [255:0] a_rdata,
  output logic [2:0]   b_raddr,
  input  logic [255:0] b_rdata,
  output logic         c_we,
  output logic [2:0]   c_waddr,
  output logic [255:0] c_wdata,
  output logic         mm_en,
  output logic [5:0]   mm_op,
  output logic [255:0] mm_a,
  output logic [255:0] mm_b,
  output logic [255:0] mm_cin,
  input  logic [255:0] mm_co
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_MAC   = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t       state_q, state_d;
  logic [2:0]   i_q, i_d;
  logic [2:0]   k_q, k_d;
  logic [255:0] acc_q, acc_d;

  // State, row/step indices and accumulator registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      i_q     <= '0;
      k_q     <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
    end
  end

  // Next-state: step through FETCH/MAC pairs, WRITE per row
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    k_d     = k_q;
    acc_d   = acc_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          i_d     = '0;
          k_d     = '0;
          acc_d   = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: state_d = S_MAC;
      S_MAC: begin
        acc_d = mm_co;
        if (k_q == 3'd7) begin
          state_d = S_WRITE;
        end else begin
          k_d     = k_q + 3'd1;
          state_d = S_FETCH;
        end
      end
      S_WRITE: begin
        if (i_q == 3'd7) begin
          state_d = S_DONE;
        end else begin
          i_d     = i_q + 3'd1;
          k_d     = '0;
          acc_d   = '0;
          state_d = S_FETCH;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from registered state; zero outside their phase
  always_comb begin
    busy    = (state_q != S_IDLE);
    done    = 1'b0;
    a_raddr = '0;
    b_raddr = '0;
    c_we    = 1'b0;
    c_waddr = '0;
    c_wdata = '0;
    mm_en   = 1'b0;
    mm_op   = '0;
    mm_a    = '0;
    mm_b    = '0;
    mm_cin  = '0;
    unique case (1'b1)
      (state_q == S_FETCH): begin
        a_raddr = i_q;
        b_raddr = k_q;
      end
      (state_q == S_MAC): begin
        a_raddr = i_q;
        b_raddr = k_q;
        mm_en   = 1'b1;
        mm_op   = {3'b000, k_q} + 6'd1;
        mm_a    = a_rdata;
        mm_b    = b_rdata;
        mm_cin  = acc_q;
      end
      (state_q == S_WRITE): begin
        c_we    = 1'b1;
        c_waddr = i_q;
        c_wdata = acc_q;
      end
      (state_q == S_DONE): done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mm_seq.sv
// tb_mm_seq: directed and seeded-random checks of mm_seq
// with row memories and a behavioural matrix_ops model.
module tb_mm_seq;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         busy, done;
  logic [2:0]   a_raddr, b_raddr, c_waddr;
  logic [255:0] a_rdata, b_rdata, c_wdata;
  logic         c_we, mm_en;
  logic [5:0]   mm_op;
  logic [255:0] mm_a, mm_b, mm_cin, mm_co;

  logic [255:0] a_mem [8];
  logic [255:0] b_mem [8];
  logic [255:0] ref_c [8];

  int tests = 0;
  int fails = 0;

  typedef struct {
    int         cyc;
    logic       en;
    logic [5:0] op;
    logic       chk_b;
    logic [2:0] braddr;
    logic       we;
    logic [2:0] waddr;
  } vec_t;

  vec_t tbl [$];

  always #5 clk = ~clk;

  mm_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .busy(busy), .done(done),
    .a_raddr(a_raddr), .a_rdata(a_rdata),
    .b_raddr(b_raddr), .b_rdata(b_rdata),
    .c_we(c_we), .c_waddr(c_waddr), .c_wdata(c_wdata),
    .mm_en(mm_en), .mm_op(mm_op),
    .mm_a(mm_a), .mm_b(mm_b), .mm_cin(mm_cin),
    .mm_co(mm_co)
  );

  // synchronous row memories
  always @(posedge clk) begin
    a_rdata <= a_mem[a_raddr];
    b_rdata <= b_mem[b_raddr];
  end

  // matrix_ops step model
  always_comb begin
    int s;
    mm_co = '0;
    s = int'(mm_op) - 1;
    if (mm_op >= 6'd1 && mm_op <= 6'd8)
      for (int j = 0; j < 8; j++)
        mm_co[32*j +: 32] = mm_a[32*s +: 32] * mm_b[32*j +: 32]
                          + mm_cin[32*j +: 32];
  end

  task automatic chk(input string nm, input logic [255:0] act,
                     input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic model_ref();
    logic [31:0] s;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) begin
        s = '0;
        for (int k = 0; k < 8; k++)
          s = s + a_mem[i][32*k +: 32] * b_mem[k][32*j +: 32];
        ref_c[i][32*j +: 32] = s;
      end
  endtask

  task automatic run(input bit extra, input bit chain,
                     input int rst_at, input bit started);
    int last;
    bit we_exp;
    if (!started) start = 1'b1;
    @(posedge clk);
    last = chain ? 138 : 140;
    for (int c = 1; c <= last; c++) begin
      @(negedge clk);
      start = 1'b0;
      chk("busy", busy, (c <= 137));
      chk("done", done, (c == 137));
      we_exp = (c >= 17 && c <= 136 && c % 17 == 0);
      chk("c_we", c_we, we_exp);
      if (we_exp) begin
        chk("c_waddr", c_waddr, c / 17 - 1);
        chk("c_wdata", c_wdata, ref_c[c / 17 - 1]);
      end
      foreach (tbl[t]) if (tbl[t].cyc == c) begin
        chk("tbl_en", mm_en, tbl[t].en);
        chk("tbl_op", mm_op, tbl[t].op);
        chk("tbl_we", c_we, tbl[t].we);
        if (tbl[t].we) chk("tbl_waddr", c_waddr, tbl[t].waddr);
        if (tbl[t].chk_b) chk("tbl_braddr", b_raddr, tbl[t].braddr);
      end
      if (c == 2) chk("mm_cin_step1", mm_cin, '0);
      if (extra && (c == 5 || c == 137)) start = 1'b1;
      if (chain && c == 138) start = 1'b1;
      if (rst_at == c) begin
        rst_n = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_we_en", {c_we, mm_en, mm_op}, 0);
        chk("rst_addr", {a_raddr, b_raddr, c_waddr}, 0);
        chk("rst_data", c_wdata | mm_a | mm_b | mm_cin, '0);
        repeat (4) begin
          @(negedge clk);
          chk("rst_hold_done", done, 0);
        end
        rst_n = 1'b1;
        repeat (3) begin
          @(negedge clk);
          chk("post_rst_idle", {busy, done}, 0);
        end
        return;
      end
    end
  endtask

  initial begin
    vec_t v;
    for (int k = 0; k < 8; k++) begin
      v = '{cyc: 2*k+1, en: 0, op: 0, chk_b: 1,
            braddr: 3'(k), we: 0, waddr: 0};
      tbl.push_back(v);
      v = '{cyc: 2*k+2, en: 1, op: 6'(k+1), chk_b: 1,
            braddr: 3'(k), we: 0, waddr: 0};
      tbl.push_back(v);
      v = '{cyc: 17*(k+1), en: 0, op: 0, chk_b: 0,
            braddr: 0, we: 1, waddr: 3'(k)};
      tbl.push_back(v);
    end
    v = '{cyc: 137, en: 0, op: 0, chk_b: 0, braddr: 0, we: 0, waddr: 0};
    tbl.push_back(v);
    v = '{cyc: 138, en: 0, op: 0, chk_b: 0, braddr: 0, we: 0, waddr: 0};
    tbl.push_back(v);

    rst_n = 1'b0;
    start = 1'b0;
    for (int r = 0; r < 8; r++) begin
      a_mem[r] = '0;
      b_mem[r] = '0;
    end
    #12;
    chk("reset_busy_done", {busy, done}, 0);
    chk("reset_ctl", {c_we, mm_en, mm_op}, 0);
    chk("reset_addr", {a_raddr, b_raddr, c_waddr}, 0);
    chk("reset_data", c_wdata | mm_a | mm_b | mm_cin, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // identity A, B lane = 16k+j; C must equal B
    for (int r = 0; r < 8; r++)
      for (int j = 0; j < 8; j++) begin
        a_mem[r][32*j +: 32] = (r == j) ? 32'd1 : 32'd0;
        b_mem[r][32*j +: 32] = 32'(16*r + j);
      end
    for (int r = 0; r < 8; r++) ref_c[r] = b_mem[r];
    run(0, 0, 0, 0);

    // per-lane wrap
    for (int r = 0; r < 8; r++) begin
      a_mem[r] = {8{32'hFFFF_FFFF}};
      b_mem[r] = {8{32'h0000_0002}};
      ref_c[r] = {8{32'hFFFF_FFF0}};
    end
    run(0, 0, 0, 0);

    // random data, ignored starts, back-to-back start at 138
    void'($urandom(32'd12345));
    for (int r = 0; r < 8; r++)
      for (int j = 0; j < 8; j++) begin
        a_mem[r][32*j +: 32] = $urandom;
        b_mem[r][32*j +: 32] = $urandom;
      end
    model_ref();
    run(1, 1, 0, 0);
    run(0, 0, 0, 1);

    // reset mid-run in row 3, then a clean full run
    run(0, 0, 60, 0);
    run(0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
